farm_sensor_detector: RTL and testbench

FARM_SENSOR_DETECTOR -- requirements
Module: farm_sensor_detector

---
 rtl/traffic_pkg.sv | 20 ++
 rtl/loop_debounce.sv | 36 +++
 rtl/farm_sensor_detector.sv | 110 +++++++++++
 tb/tb_farm_sensor_detector.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Lamp encodings and detector state encoding shared between the farm-road
// sensor detector and the traffic light controller.
package traffic_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        DET_IDLE    = 2'd0,
        DET_REQUEST = 2'd1,
        DET_SERVING = 2'd2
    } det_state_e;

    // Only the exact GREEN code is green; illegal lamp codes are treated as not green.
    function automatic logic is_green(input logic [2:0] lamp);
        return lamp == LAMP_GREEN;
    endfunction

endpackage

// File: rtl/loop_debounce.sv
// Two-flop synchronizer followed by a level debounce filter for the loop detector.
// The output flips only after DEBOUNCE_CYC+1 consecutive disagreeing samples.
module loop_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic       sync1;
    logic       sync2;
    logic [7:0] mismatch_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            dout         <= 1'b0;
            mismatch_cnt <= 8'd0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == dout) begin
                mismatch_cnt <= 8'd0;
            end else if (mismatch_cnt == 8'(DEBOUNCE_CYC)) begin
                dout         <= sync2;
                mismatch_cnt <= 8'd0;
            end else begin
                mismatch_cnt <= mismatch_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/farm_sensor_detector.sv
// Farm-road vehicle detector: counts queued vehicles from the debounced loop,
// raises a service request to the light controller and flags a stuck loop.
module farm_sensor_detector
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int QUEUE_MAX    = 15,
    parameter int STUCK_CYC    = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       loop_raw,
    input  logic [2:0] light_farm,
    output logic       sensor,
    output logic [3:0] queue_count,
    output logic       queue_full,
    output logic       stuck_fault,
    output logic [1:0] state
);

    localparam logic [3:0]  QMAX       = 4'(QUEUE_MAX);
    localparam logic [15:0] STUCK_LAST = 16'(STUCK_CYC - 1);

    logic        loop_flt;
    logic        flt_d;
    logic        green;
    logic        rise;
    logic        fall;
    logic [3:0]  q_next;
    logic [15:0] high_cnt;
    det_state_e  state_r;

    loop_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (loop_raw),
        .dout (loop_flt)
    );

    assign green = is_green(light_farm);
    assign rise  = loop_flt & ~flt_d;
    assign fall  = ~loop_flt & flt_d;
    assign state = state_r;

    // A stuck loop freezes the count so a permanently occupied loop cannot drain it.
    always_comb begin
        q_next = queue_count;
        if (!stuck_fault) begin
            if (rise && !green && queue_count != QMAX) begin
                q_next = queue_count + 4'd1;
            end else if (fall && green && queue_count != 4'd0) begin
                q_next = queue_count - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_d       <= 1'b0;
            queue_count <= 4'd0;
            queue_full  <= 1'b0;
            high_cnt    <= 16'd0;
            stuck_fault <= 1'b0;
        end else begin
            flt_d       <= loop_flt;
            queue_count <= q_next;
            queue_full  <= (q_next == QMAX);
            if (loop_flt) begin
                if (high_cnt == STUCK_LAST) begin
                    stuck_fault <= 1'b1;
                end else begin
                    high_cnt <= high_cnt + 16'd1;
                end
            end else begin
                high_cnt <= 16'd0;
            end
        end
    end

    // The state follows the count it is about to hold; sensor trails the state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= DET_IDLE;
            sensor  <= 1'b0;
        end else begin
            sensor <= (state_r != DET_IDLE) || stuck_fault;
            case (state_r)
                DET_IDLE: begin
                    if (q_next != 4'd0) begin
                        state_r <= green ? DET_SERVING : DET_REQUEST;
                    end
                end
                DET_REQUEST: begin
                    if (green) begin
                        state_r <= DET_SERVING;
                    end
                end
                DET_SERVING: begin
                    if (q_next == 4'd0) begin
                        state_r <= DET_IDLE;
                    end else if (!green) begin
                        state_r <= DET_REQUEST;
                    end
                end
                default: state_r <= DET_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_farm_sensor_detector.sv
// Bench for farm_sensor_detector: directed scenarios plus randomized loop/lamp
// traffic compared cycle by cycle against a behavioural model.
module tb_farm_sensor_detector;
    import traffic_pkg::*;

    localparam int D  = 4;
    localparam int QM = 15;
    localparam int SC = 1024;

    logic       clk;
    logic       rst_n;
    logic       loop_raw;
    logic [2:0] light_farm;
    logic       sensor;
    logic [3:0] queue_count;
    logic       queue_full;
    logic       stuck_fault;
    logic [1:0] state;

    int checks;
    int failures;

    farm_sensor_detector #(.DEBOUNCE_CYC(D), .QUEUE_MAX(QM), .STUCK_CYC(SC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .loop_raw   (loop_raw),
        .light_farm (light_farm),
        .sensor     (sensor),
        .queue_count(queue_count),
        .queue_full (queue_full),
        .stuck_fault(stuck_fault),
        .state      (state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: filtered level flips when the last D+1 synchronized
    // samples all disagree with it; service state 0=idle 1=request 2=serving.
    logic raw_hist[$];
    bit   m_flt, m_flt_d, m_stuck, m_sensor, m_full, m_green, m_all_opp;
    int   m_q, m_state, m_hi, n_q, n_state;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_hist.delete();
            for (int i = 0; i < D + 3; i++) raw_hist.push_back(1'b0);
            m_flt = 0; m_flt_d = 0; m_stuck = 0; m_sensor = 0; m_full = 0;
            m_q = 0; m_state = 0; m_hi = 0;
        end else begin
            m_green = (light_farm == 3'b001);
            n_q = m_q;
            if (!m_stuck) begin
                if (m_flt && !m_flt_d && !m_green) n_q = (m_q < QM) ? m_q + 1 : m_q;
                else if (!m_flt && m_flt_d && m_green) n_q = (m_q > 0) ? m_q - 1 : 0;
            end
            n_state = m_state;
            if (m_state == 0 && n_q != 0) n_state = m_green ? 2 : 1;
            else if (m_state == 1 && m_green) n_state = 2;
            else if (m_state == 2 && n_q == 0) n_state = 0;
            else if (m_state == 2 && !m_green) n_state = 1;
            m_sensor = (m_state != 0) || m_stuck;
            if (m_flt) begin
                m_hi++;
                if (m_hi >= SC) m_stuck = 1;
            end else begin
                m_hi = 0;
            end
            m_q = n_q;
            m_full = (n_q == QM);
            m_state = n_state;
            raw_hist.push_back(loop_raw);
            m_all_opp = 1;
            for (int j = raw_hist.size() - 3 - D; j <= raw_hist.size() - 3; j++)
                if (raw_hist[j] == m_flt) m_all_opp = 0;
            m_flt_d = m_flt;
            if (m_all_opp) m_flt = !m_flt;
            if (raw_hist.size() > 64) void'(raw_hist.pop_front());
        end
    end

    // Driver tasks
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic car_pulse();
        loop_raw = 1'b1;
        repeat (8) @(negedge clk);
        loop_raw = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        loop_raw = 1'b1;
        light_farm = LAMP_RED;
        repeat (3) @(negedge clk);
        checks++;
        if (sensor !== 1'b0 || queue_count !== 4'd0 || queue_full !== 1'b0 || stuck_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: sensor=%b q=%0d full=%b stuck=%b, required all 0",
                     sensor, queue_count, queue_full, stuck_fault);
        end
        rst_n = 1'b1;
        // edge 0 is the first rising edge after release
        for (int e = 0; e <= 10; e++) begin
            @(negedge clk);
            checks++;
            if (queue_count !== ((e >= 7) ? 4'd1 : 4'd0)) begin
                failures++;
                $display("FAIL reset_latency_q: edge %0d q=%0d required %0d", e, queue_count, (e >= 7) ? 1 : 0);
            end
            checks++;
            if (sensor !== ((e >= 8) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL reset_latency_sensor: edge %0d sensor=%b required %b", e, sensor, (e >= 8));
            end
        end
        loop_raw = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_glitch();
        do_reset();
        light_farm = LAMP_RED;
        loop_raw = 1'b1;
        repeat (3) @(negedge clk);
        loop_raw = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            checks++;
            if (queue_count !== 4'd0 || sensor !== 1'b0) begin
                failures++;
                $display("FAIL glitch: cycle %0d q=%0d sensor=%b required q=0 sensor=0", c, queue_count, sensor);
            end
        end
    endtask

    task automatic test_queue();
        bit seen_idle;
        bit check_next;
        logic [1:0] prev_state;
        do_reset();
        light_farm = LAMP_RED;
        repeat (3) car_pulse();
        repeat (10) @(negedge clk);
        checks++;
        if (queue_count !== 4'd3 || sensor !== 1'b1) begin
            failures++;
            $display("FAIL queue_three: q=%0d sensor=%b required q=3 sensor=1", queue_count, sensor);
        end
        light_farm = LAMP_GREEN;
        repeat (3) @(negedge clk);
        seen_idle = 0;
        check_next = 0;
        prev_state = state;
        for (int c = 0; c < 70; c++) begin
            loop_raw = (c < 48) && ((c % 16) < 8);
            @(negedge clk);
            if (check_next) begin
                check_next = 0;
                checks++;
                if (sensor !== 1'b0) begin
                    failures++;
                    $display("FAIL queue_sensor_drop: sensor=%b required 0 one cycle after IDLE", sensor);
                end
            end
            if (!seen_idle && state == DET_IDLE && prev_state != DET_IDLE) begin
                seen_idle = 1;
                check_next = 1;
                checks++;
                if (sensor !== 1'b1) begin
                    failures++;
                    $display("FAIL queue_sensor_hold: sensor=%b required 1 on the IDLE entry cycle", sensor);
                end
            end
            prev_state = state;
        end
        checks++;
        if (!seen_idle || queue_count !== 4'd0) begin
            failures++;
            $display("FAIL queue_drain: idle_seen=%b q=%0d required idle_seen=1 q=0", seen_idle, queue_count);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        light_farm = LAMP_RED;
        repeat (16) car_pulse();
        repeat (10) @(negedge clk);
        checks++;
        if (queue_count !== 4'd15 || queue_full !== 1'b1) begin
            failures++;
            $display("FAIL saturate: q=%0d full=%b required q=15 full=1", queue_count, queue_full);
        end
        light_farm = LAMP_GREEN;
        car_pulse();
        repeat (10) @(negedge clk);
        checks++;
        if (queue_count !== 4'd14 || queue_full !== 1'b0) begin
            failures++;
            $display("FAIL saturate_leave: q=%0d full=%b required q=14 full=0", queue_count, queue_full);
        end
    endtask

    task automatic test_yellow();
        do_reset();
        light_farm = LAMP_RED;
        repeat (2) car_pulse();
        repeat (10) @(negedge clk);
        light_farm = LAMP_GREEN;
        car_pulse();
        repeat (10) @(negedge clk);
        checks++;
        if (queue_count !== 4'd1 || state !== DET_SERVING) begin
            failures++;
            $display("FAIL yellow_serving: q=%0d state=%0d required q=1 state=%0d", queue_count, state, DET_SERVING);
        end
        light_farm = LAMP_YELLOW;
        repeat (2) @(negedge clk);
        checks++;
        if (state !== DET_REQUEST || sensor !== 1'b1 || queue_count !== 4'd1) begin
            failures++;
            $display("FAIL yellow_request: state=%0d sensor=%b q=%0d required state=%0d sensor=1 q=1",
                     state, sensor, queue_count, DET_REQUEST);
        end
        // 3'b111 is not green: the pulse arrives but cannot depart
        light_farm = 3'b111;
        car_pulse();
        repeat (10) @(negedge clk);
        checks++;
        if (queue_count !== 4'd2 || state !== DET_REQUEST || sensor !== 1'b1) begin
            failures++;
            $display("FAIL illegal_lamp: q=%0d state=%0d sensor=%b required q=2 state=%0d sensor=1",
                     queue_count, state, sensor, DET_REQUEST);
        end
    endtask

    task automatic test_random();
        int len;
        logic raw;
        do_reset();
        light_farm = LAMP_RED;
        for (int seg = 0; seg < 150; seg++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 4))
                    0: light_farm = LAMP_RED;
                    1: light_farm = LAMP_YELLOW;
                    2: light_farm = LAMP_GREEN;
                    3: light_farm = 3'b111;
                    default: light_farm = 3'($urandom_range(0, 7));
                endcase
            end
            len = $urandom_range(1, 14);
            raw = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                loop_raw = raw;
                @(negedge clk);
                checks++;
                if (queue_count !== 4'(m_q) || sensor !== m_sensor || queue_full !== m_full || stuck_fault !== m_stuck) begin
                    failures++;
                    $display("FAIL random: q=%0d sensor=%b full=%b stuck=%b required q=%0d sensor=%b full=%b stuck=%b",
                             queue_count, sensor, queue_full, stuck_fault, m_q, m_sensor, m_full, m_stuck);
                end
            end
        end
        loop_raw = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_stuck();
        int first_stuck;
        do_reset();
        light_farm = LAMP_RED;
        first_stuck = -1;
        // c indexes the negedge after the c-th rising edge since loop_raw rose
        for (int c = 0; c < 1100; c++) begin
            loop_raw = 1'b1;
            @(negedge clk);
            if (first_stuck < 0 && stuck_fault === 1'b1) first_stuck = c;
            checks++;
            if (stuck_fault !== m_stuck || sensor !== m_sensor || queue_count !== 4'(m_q)) begin
                failures++;
                $display("FAIL stuck_track: cycle %0d stuck=%b sensor=%b q=%0d required stuck=%b sensor=%b q=%0d",
                         c, stuck_fault, sensor, queue_count, m_stuck, m_sensor, m_q);
            end
        end
        checks++;
        if (first_stuck != 6 + SC) begin
            failures++;
            $display("FAIL stuck_time: stuck at cycle %0d required %0d", first_stuck, 6 + SC);
        end
        light_farm = LAMP_GREEN;
        loop_raw = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (stuck_fault !== 1'b1 || sensor !== 1'b1 || queue_count !== 4'd1) begin
            failures++;
            $display("FAIL stuck_hold: stuck=%b sensor=%b q=%0d required stuck=1 sensor=1 q=1",
                     stuck_fault, sensor, queue_count);
        end
        // asynchronous assertion between clock edges
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (stuck_fault !== 1'b0 || sensor !== 1'b0 || queue_count !== 4'd0 || queue_full !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: stuck=%b sensor=%b q=%0d full=%b required all 0",
                     stuck_fault, sensor, queue_count, queue_full);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (stuck_fault !== 1'b0 || sensor !== 1'b0) begin
            failures++;
            $display("FAIL stuck_cleared: stuck=%b sensor=%b required 0 0", stuck_fault, sensor);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        loop_raw = 1'b0;
        light_farm = LAMP_RED;
        @(negedge clk);
        test_reset();
        test_glitch();
        test_queue();
        test_saturation();
        test_yellow();
        test_random();
        test_stuck();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
